uart_baud_gen: RTL and testbench

Programmable UART baud-tick generator. It produces a 1-cycle oversampling strobe (`os_tick`) and a 1-cycle bit-rate strobe (`bit_tick`) from the system clock. The divisor can be changed at runtime, glitch-free, and has an optional fractional part. It sits between the clock domain root and the UART receiver and transmitter, which consume `os_tick` and `bit_tick` respectively.

---
 rtl/uart_baud_pkg.sv | 19 +
 rtl/uart_baud_phase.sv | 36 +++
 rtl/uart_baud_gen.sv | 135 +++++++++++++
 tb/tb_uart_baud_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_baud_pkg.sv
// Shared defaults and helpers for the UART baud-tick generator.
// The fractional divisor is built only when UART_BAUD_FRAC_EN is defined.
package uart_baud_pkg;

    localparam int DEF_DIV_W       = 16;
    localparam int DEF_FRAC_W      = 4;
    localparam int DEF_OSR         = 16;
    localparam int DEF_DEFAULT_DIV = 163;

    // Smallest usable integer divisor: a period of 1 would leave no idle
    // cycle between strobes.
    localparam int unsigned MIN_DIV = 2;

    // Clamp a requested integer divisor to the minimum supported value.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_baud_phase.sv
// Oversample phase counter: counts os_tick strobes within one bit and
// raises bit_tick together with the os_tick that closes each bit.
// Takes the pre-register wrap strobe so bit_tick lines up with os_tick.
module uart_baud_phase
    import uart_baud_pkg::*;
#(
    parameter int OSR = DEF_OSR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wrap,
    input  logic                   resync,
    output logic [$clog2(OSR)-1:0] os_phase,
    output logic                   bit_tick
);

    localparam int PH_W = $clog2(OSR);
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(OSR - 1);

    // Advance the phase on every wrap; the wrap leaving the last phase is the bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_phase <= '0;
            bit_tick <= 1'b0;
        end else if (resync) begin
            os_phase <= '0;
            bit_tick <= 1'b0;
        end else begin
            bit_tick <= wrap && (os_phase == LAST_PHASE);
            if (wrap) begin
                os_phase <= (os_phase == LAST_PHASE) ? '0 : os_phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART baud-tick generator with a glitch-free runtime divisor
// change. Build option: define UART_BAUD_FRAC_EN to add the fractional
// accumulator; without it div_frac is ignored and period = integer divisor.
//
// Divisor handshake: a one-cycle div_load captures div_int/div_frac into a
// shadow register and marks it pending. The pending value becomes active at
// the next wrap (immediately on the next edge while en is low, or on a
// resync edge), and div_ack pulses for one cycle right after that commit.
// Loads that arrive before the commit simply overwrite the shadow value.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int FRAC_W      = DEF_FRAC_W,
    parameter int OSR         = DEF_OSR,
    parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DIV_W-1:0]       div_int,
    input  logic [FRAC_W-1:0]      div_frac,
    input  logic                   div_load,
    output logic                   div_ack,
    input  logic                   resync,
    output logic                   os_tick,
    output logic                   bit_tick,
    output logic [$clog2(OSR)-1:0] os_phase
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_int;
    logic [DIV_W-1:0] shadow_int;
    logic             pending;
    logic             carry;
    logic [DIV_W:0]   period;
    logic             wrap;
    logic             commit;

    // The current period stretches by one cycle whenever the fraction
    // accumulator overflows on this wrap.
    assign period = {1'b0, act_int} + (DIV_W + 1)'(carry);
    assign wrap   = en && ({1'b0, cnt} == (period - 1'b1));
    assign commit = pending && (resync || wrap || !en);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] shadow_frac;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, acc} + {1'b0, act_frac};
    assign carry    = frac_sum[FRAC_W];

    // Fraction accumulator advances once per completed period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (resync) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= frac_sum[FRAC_W-1:0];
        end
    end

    // Shadow and active fraction follow the same load/commit rules as the integer part.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_frac <= '0;
            act_frac    <= '0;
        end else begin
            if (commit) begin
                act_frac <= shadow_frac;
            end
            if (div_load) begin
                shadow_frac <= div_frac;
            end
        end
    end
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^div_frac;
`endif

    // Period counter and the registered oversampling strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (resync) begin
            cnt     <= '0;
            os_tick <= 1'b0;
        end else if (en) begin
            os_tick <= wrap;
            cnt     <= wrap ? '0 : cnt + 1'b1;
        end else begin
            os_tick <= 1'b0;
        end
    end

    // Shadow capture, commit into the active divisor, and the ack pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_int    <= DIV_W'(DEFAULT_DIV);
            shadow_int <= '0;
            pending    <= 1'b0;
            div_ack    <= 1'b0;
        end else begin
            div_ack <= commit;
            if (commit) begin
                act_int <= DIV_W'(clamp_div(32'(shadow_int)));
            end
            if (div_load) begin
                shadow_int <= div_int;
                pending    <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    uart_baud_phase #(
        .OSR(OSR)
    ) u_phase (
        .clk     (clk),
        .rst     (rst),
        .wrap    (wrap),
        .resync  (resync),
        .os_phase(os_phase),
        .bit_tick(bit_tick)
    );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed-plus-random bench for uart_baud_gen. Expected tick spacing comes
// from the arithmetic average-period rule; expected phase comes from the
// number of ticks seen since the last reset or resync.
module tb_uart_baud_gen;

    localparam int OSR = 16;
`ifdef UART_BAUD_FRAC_EN
    localparam int FRAC_EN = 1;
`else
    localparam int FRAC_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        div_ack;
    logic        resync;
    logic        os_tick;
    logic        bit_tick;
    logic [3:0]  os_phase;

    int checks   = 0;
    int errors   = 0;
    int tick_cnt = 0;
    int exp_q[$];

    uart_baud_gen dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_int (div_int),
        .div_frac(div_frac),
        .div_load(div_load),
        .div_ack (div_ack),
        .resync  (resync),
        .os_tick (os_tick),
        .bit_tick(bit_tick),
        .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference period of the k-th wrap after the accumulator was cleared:
    // average period int + frac/16, distributed by floor differences.
    function automatic int model_period(input int di, input int df, input int k);
        int base;
        base = (di < 2) ? 2 : di;
        if (FRAC_EN != 0) return base + ((k + 1) * df) / 16 - (k * df) / 16;
        return base;
    endfunction

    // Count negedges until the next os_tick; checks phase/bit_tick on it.
    task automatic wait_tick(input string tag, output int n, output int acks);
        n = 0;
        acks = 0;
        do begin
            @(negedge clk);
            n++;
            if (div_ack) acks++;
        end while (!os_tick && n < 4000);
        if (!os_tick) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            tick_cnt++;
            check({tag, " phase"}, 32'(os_phase), 32'(tick_cnt % OSR));
            check({tag, " bit_tick"}, 32'(bit_tick), 32'((tick_cnt % OSR) == 0));
        end
    endtask

    task automatic pulse_load(input int di, input int df);
        div_int  = 16'(di);
        div_frac = 4'(df);
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(negedge clk);
    endtask

    initial begin
        int n, a, sum, old, d, o, di, df, seen;
        rst = 1'b1; en = 1'b0; div_load = 1'b0; resync = 1'b0;
        div_int = '0; div_frac = '0;
        idle(3);
        check("rst os_tick", 32'(os_tick), 32'd0);
        check("rst bit_tick", 32'(bit_tick), 32'd0);
        check("rst div_ack", 32'(div_ack), 32'd0);
        check("rst os_phase", 32'(os_phase), 32'd0);

        // Default divisor from reset release.
        rst = 1'b0; en = 1'b1; tick_cnt = 0;
        wait_tick("first", n, a);
        check("first gap", 32'(n), 32'd163);
        check("first acks", 32'(a), 32'd0);
        sum = 0;
        for (int k = 2; k <= 32; k++) begin
            wait_tick("dflt", n, a);
            check("dflt gap", 32'(n), 32'd163);
            if (k > 16) sum += n;
        end
        check("bit spacing", 32'(sum), 32'd2608);

        // Load while disabled: ack two cycles after the request.
        en = 1'b0;
        pulse_load(50, 0);
        check("dis ack early", 32'(div_ack), 32'd0);
        idle(1);
        check("dis ack", 32'(div_ack), 32'd1);
        idle(1);
        check("dis ack pulse", 32'(div_ack), 32'd0);
        check("dis no tick", 32'(os_tick), 32'd0);
        en = 1'b1;
        wait_tick("after dis", n, a);
        check("after dis gap", 32'(n), 32'd50);

        // Load 20 at cnt=5 of 50: old period finishes, ack on that wrap.
        idle(5);
        pulse_load(20, 0);
        wait_tick("mid load", n, a);
        check("mid load gap", 32'(n), 32'd44);
        check("mid load ack", 32'(div_ack), 32'd1);
        check("mid load acks", 32'(a), 32'd1);
        repeat (2) begin
            wait_tick("new20", n, a);
            check("new20 gap", 32'(n), 32'd20);
            check("new20 acks", 32'(a), 32'd0);
        end

        // Random loads at random offsets, occasionally below the clamp.
        old = 20;
        repeat (5) begin
            d = $urandom_range(0, 40);
            o = $urandom_range(0, old - 2);
            idle(o);
            pulse_load(d, 0);
            wait_tick("rnd old", n, a);
            check("rnd old gap", 32'(n), 32'(old - o - 1));
            check("rnd acks", 32'(a), 32'd1);
            old = model_period(d, 0, 0);
            wait_tick("rnd new", n, a);
            check("rnd new gap", 32'(n), 32'(old));
            check("rnd new acks", 32'(a), 32'd0);
        end

        // Two loads before one commit: last one wins, single ack.
        pulse_load(30, 0);
        wait_tick("pre30", n, a);
        check("pre30 gap", 32'(n), 32'(old - 1));
        wait_tick("p30", n, a);
        check("p30 gap", 32'(n), 32'd30);
        idle(3);
        pulse_load(12, 0);
        idle(1);
        pulse_load(25, 0);
        wait_tick("dbl old", n, a);
        check("dbl old gap", 32'(n), 32'd24);
        check("dbl acks", 32'(a), 32'd1);
        wait_tick("dbl new", n, a);
        check("dbl new gap", 32'(n), 32'd25);
        check("dbl new acks", 32'(a), 32'd0);

        // Back to 50, then resync at cnt=40.
        pulse_load(50, 0);
        wait_tick("pre50", n, a);
        wait_tick("p50", n, a);
        check("p50 gap", 32'(n), 32'd50);
        idle(40);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        tick_cnt = 0;
        check("resync tick", 32'(os_tick), 32'd0);
        check("resync phase", 32'(os_phase), 32'd0);
        wait_tick("post resync", n, a);
        check("post resync gap", 32'(n), 32'd50);

        // Resync commits a pending load on the same edge.
        d = $urandom_range(2, 40);
        idle(7);
        pulse_load(d, 0);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        tick_cnt = 0;
        check("resync ack", 32'(div_ack), 32'd1);
        check("resync phase2", 32'(os_phase), 32'd0);
        wait_tick("resync load", n, a);
        check("resync load gap", 32'(n), 32'(d));
        check("resync load acks", 32'(a), 32'd0);

        // Clamp: 0 while disabled, then 1 while running.
        en = 1'b0;
        pulse_load(0, 0);
        idle(1);
        en = 1'b1;
        repeat (3) begin
            wait_tick("clamp0", n, a);
            check("clamp0 gap", 32'(n), 32'd2);
        end
        pulse_load(1, 0);
        wait_tick("clamp1 pre", n, a);
        check("clamp1 pre gap", 32'(n), 32'd1);
        repeat (3) begin
            wait_tick("clamp1", n, a);
            check("clamp1 gap", 32'(n), 32'd2);
        end

        // Fractional divisor: directed 10 + 8/16, then a random one.
        for (int t = 0; t < 2; t++) begin
            di = (t == 0) ? 10 : $urandom_range(3, 12);
            df = (t == 0) ? 8 : $urandom_range(1, 15);
            en = 1'b0;
            pulse_load(di, df);
            idle(1);
            resync = 1'b1;
            @(negedge clk);
            resync = 1'b0;
            tick_cnt = 0;
            en = 1'b1;
            for (int k = 0; k < 16; k++) exp_q.push_back(model_period(di, df, k));
            sum = 0;
            for (int k = 0; k < 16; k++) begin
                wait_tick("frac", n, a);
                check("frac gap", 32'(n), 32'(exp_q.pop_front()));
                sum += n;
            end
            check("frac span", 32'(sum), 32'(16 * di + FRAC_EN * df));
        end

        // Reset mid-period with a load pending: divisor returns to default.
        idle(20);
        pulse_load(7, 0);
        rst = 1'b1;
        #1;
        check("mid rst os_tick", 32'(os_tick), 32'd0);
        check("mid rst bit_tick", 32'(bit_tick), 32'd0);
        check("mid rst div_ack", 32'(div_ack), 32'd0);
        check("mid rst os_phase", 32'(os_phase), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick_cnt = 0;
        wait_tick("after rst", n, a);
        check("after rst gap", 32'(n), 32'd163);
        check("after rst acks", 32'(a), 32'd0);

        // Drop en at cnt=100 for 30 cycles: tick delayed by exactly 30.
        idle(100);
        en = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (os_tick) seen++;
        end
        check("en low ticks", 32'(seen), 32'd0);
        en = 1'b1;
        wait_tick("en resume", n, a);
        check("en resume gap", 32'(n), 32'd63);
        wait_tick("en steady", n, a);
        check("en steady gap", 32'(n), 32'd163);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
